hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the in-order 16-bit pipeline, sitting beside the ID stage.
//  Per-register pending-write countdown scoreboard detects RAW hazards without comparing stage destination fields.
//  A branch-penalty counter freezes and flushes fetch for a configurable number of cycles after a control instruction issues.

---
 rtl/hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/branch hazard unit beside the ID stage
//
// Purpose: per-register pending-write countdown scoreboard for RAW detection,
// a branch-penalty counter that freezes/flushes fetch after a control
// instruction issues, and a saturating RAW-stall cycle counter.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs1/id_rs1_used         source 1 index / actually read
//   id_rs2/id_rs2_used         source 2 index / actually read
//   id_wr_en/id_wr_reg         instruction writes id_wr_reg
//   id_is_ctrl                 branch/jump in ID
//   pc_write                   allow sequential PC advance
//   if_id_write/if_id_flush    IF/ID enable / bubble load
//   nop                        bubble into ID/EX
//   busy_mask                  bit r set while reg r is not yet readable
//   stall_cnt                  RAW-stall cycles since reset, saturating
module hazard_scoreboard #(
  parameter int NUM_REGS   = 8,
  parameter int REG_AW     = 3,
  parameter int WB_LAT     = 3,
  parameter int RF_BYPASS  = 1,
  parameter int BR_PENALTY = 2,
  parameter int STAT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic                id_rs1_used,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs2_used,
  input  logic                id_wr_en,
  input  logic [REG_AW-1:0]   id_wr_reg,
  input  logic                id_is_ctrl,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                nop,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [STAT_W-1:0]   stall_cnt
);

  localparam int CW    = $clog2(WB_LAT + 1);
  localparam int BW    = $clog2(BR_PENALTY + 1);
  localparam int IDX_N = 1 << REG_AW;

  logic [CW-1:0]     cnt_q [NUM_REGS];
  logic [CW-1:0]     cnt_d [NUM_REGS];
  logic [BW-1:0]     br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [NUM_REGS-1:0] busy;
  logic [IDX_N-1:0]    busy_ext;
  logic                frz, raw, iss;

  // A register is busy while its countdown is above the bypass threshold:
  // with write-before-read the writeback cycle itself is already readable.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = int'(cnt_q[r]) > RF_BYPASS;
    end
  end

  // Index space padded to 2**REG_AW so out-of-range sources read as not busy.
  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy;
  end

  always_comb begin
    frz = (br_cnt_q != '0);
    raw = id_valid & ~frz &
          ((id_rs1_used & busy_ext[id_rs1]) | (id_rs2_used & busy_ext[id_rs2]));
    iss = id_valid & ~frz & ~raw;
  end

  // Next state. The hazard check above uses pre-issue state, so an
  // instruction reading its own destination never stalls on itself.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];
      // Issue load wins over the decrement (WAW reload); indices beyond
      // NUM_REGS never match, so they load nothing.
      if (iss && id_wr_en && (id_wr_reg == REG_AW'(r))) begin
        cnt_d[r] = CW'(WB_LAT);
      end
    end

    br_cnt_d = br_cnt_q;
    if (iss && id_is_ctrl) begin
      br_cnt_d = BW'(BR_PENALTY);
    end else if (br_cnt_q != '0) begin
      br_cnt_d = br_cnt_q - BW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (raw && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      br_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      br_cnt_q    <= br_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs by priority: freeze, RAW stall, issuing control, normal.
  // Held reset forces a stalled, empty-looking pipeline immediately.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    nop         = 1'b0;
    busy_mask   = busy;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      nop         = 1'b1;
      busy_mask   = '0;
    end else if (frz) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      nop         = 1'b1;
    end else if (raw) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      nop         = 1'b1;
    end else if (iss && id_is_ctrl) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int NR   = 8;
  localparam int WBL  = 3;
  localparam int BYP  = 1;
  localparam int BRP  = 2;
  localparam int SW   = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_ctrl;
  logic [2:0]    id_rs1, id_rs2, id_wr_reg;
  logic          pc_write, if_id_write, if_id_flush, nop;
  logic [NR-1:0] busy_mask;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle numbers. ready[r] is the first cycle in
  // which r may be read; fr_end is the first cycle no longer frozen.
  int cyc = 0;
  int ready [NR];
  int fr_end = 0;
  int m_stall = 0;
  int snap;

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_AW(3), .WB_LAT(WBL), .RF_BYPASS(BYP),
    .BR_PENALTY(BRP), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_ctrl(id_is_ctrl),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .nop(nop), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) ready[r] = 0;
    fr_end  = 0;
    m_stall = 0;
  endtask

  task automatic chk_forced(input string tag);
    chk({tag, "_pc"},    32'(pc_write),    32'd0);
    chk({tag, "_ifw"},   32'(if_id_write), 32'd0);
    chk({tag, "_flush"}, 32'(if_id_flush), 32'd0);
    chk({tag, "_nop"},   32'(nop),         32'd1);
    chk({tag, "_busy"},  32'(busy_mask),   32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt),   32'd0);
  endtask

  // One ID cycle: drive, compare at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [2:0] a, input logic ua,
                      input logic [2:0] b, input logic ub,
                      input logic we, input logic [2:0] w, input logic c);
    logic frz, vv, raw, iss;
    logic [NR-1:0] bm;
    id_valid = v; id_rs1 = a; id_rs1_used = ua; id_rs2 = b; id_rs2_used = ub;
    id_wr_en = we; id_wr_reg = w; id_is_ctrl = c;
    @(negedge clk);
    frz = (cyc < fr_end);
    vv  = v && !frz;
    raw = vv && ((ua && cyc < ready[a]) || (ub && cyc < ready[b]));
    iss = vv && !raw;
    for (int r = 0; r < NR; r++) bm[r] = (cyc < ready[r]);
    chk("pc_write",    32'(pc_write),    32'(!(frz || raw || (iss && c))));
    chk("if_id_write", 32'(if_id_write), 32'(!raw));
    chk("if_id_flush", 32'(if_id_flush), 32'(frz || (iss && c)));
    chk("nop",         32'(nop),         32'(frz || raw));
    chk("busy_mask",   32'(busy_mask),   32'(bm));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    // Result written in cycle cyc+WBL; readable from cyc+WBL+1-BYP.
    if (iss && we) ready[w] = cyc + WBL + 1 - BYP;
    if (iss && c) fr_end = cyc + BRP + 1;
    if (raw && m_stall < SMAX) m_stall++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_ctrl = 0;
    rst_n = 0;
    @(negedge clk);
    chk_forced("rst_init");
    @(posedge clk); #1;
    rst_n = 1;

    // 1: writer R3, consumer stalls 2 cycles then issues
    step(1, 0, 0, 0, 0, 1, 3'd3, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd3, 1, 3'd0, 0, 0, 0, 0);
    chk("t1_stall_total", 32'(stall_cnt), 32'd2);
    idle(3);

    // 2: unused rs1 never stalls; spaced R3->R4 chain has no overlap
    snap = int'(stall_cnt);
    step(1, 0, 0, 0, 0, 1, 3'd3, 0);
    step(1, 3'd3, 0, 3'd3, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3'd3, 0);
    idle(2);
    step(1, 3'd3, 1, 3'd0, 0, 1, 3'd4, 0);
    idle(2);
    step(1, 3'd4, 1, 3'd4, 1, 0, 0, 0);
    idle(3);
    chk("t2_no_stall", 32'(stall_cnt), 32'(snap));
    chk("t2_busy_clear", 32'(busy_mask), 32'd0);

    // 3: WAW reload on R5, reader stalls cycles 2-3
    snap = int'(stall_cnt);
    step(1, 0, 0, 0, 0, 1, 3'd5, 0);
    step(1, 0, 0, 0, 0, 1, 3'd5, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd0, 0, 3'd5, 1, 0, 0, 0);
    chk("t3_waw_stalls", 32'(stall_cnt), 32'(snap + 2));
    idle(3);

    // 4: branch, two frozen cycles with valid ignored, then normal
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 3'd1, 1, 3'd2, 1, 1, 3'd6, 1);
    step(1, 3'd1, 1, 3'd2, 1, 1, 3'd6, 0);
    step(1, 3'd6, 1, 3'd6, 1, 0, 0, 0);
    chk("t4_no_load_frz", 32'(busy_mask), 32'd0);
    idle(2);

    // 5: branch stalled by RAW on rs1 issues only after the stall
    step(1, 0, 0, 0, 0, 1, 3'd2, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd2, 1, 3'd0, 0, 0, 0, 1);
    idle(4);

    // stall counter saturation
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0, 0, 0, 1, 3'd1, 0);
      for (int i = 0; i < 3; i++) step(1, 3'd1, 1, 3'd0, 0, 0, 0, 0);
    end
    chk("sat_value", 32'(stall_cnt), 32'(SMAX));

    // 6: reset mid-chain, outputs forced at once, clean after release
    step(1, 0, 0, 0, 0, 1, 3'd2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk_forced("rst_mid");
    @(negedge clk);
    chk_forced("rst_hold");
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    step(1, 3'd2, 1, 3'd2, 1, 0, 0, 0);
    chk("post_rst_pc", 32'(pc_write), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 7) != 0, 3'($urandom), 1'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
